// File: rtl/phase_sequencer_if.sv
// Control/status bundle for phase_sequencer: sequencing controls in, phase enables and status out.
interface phase_sequencer_if #(
  parameter int NUM_PHASES = 2,
  parameter int CNT_W      = 8,
  parameter int CYC_W      = 16
);
  localparam int IDX_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

  logic                        run;
  logic                        step_mode;
  logic                        step;
  logic                        stall;
  logic [NUM_PHASES*CNT_W-1:0] phase_len;
  logic [NUM_PHASES-1:0]       phase_en;
  logic [IDX_W-1:0]            phase_idx;
  logic                        phase_first;
  logic                        phase_last;
  logic                        cycle_done;
  logic [CYC_W-1:0]            cycle_count;
  logic                        busy;

  modport master (
    output run, step_mode, step, stall, phase_len,
    input  phase_en, phase_idx, phase_first, phase_last, cycle_done, cycle_count, busy
  );

  modport slave (
    input  run, step_mode, step, stall, phase_len,
    output phase_en, phase_idx, phase_first, phase_last, cycle_done, cycle_count, busy
  );
endinterface

// File: rtl/phase_sequencer.sv
// Instruction-cycle phase sequencer: steps through NUM_PHASES phases of programmable length,
// producing one-hot registered phase clock enables with stall, single-step and cycle counting.
module phase_sequencer #(
  parameter int NUM_PHASES = 2,
  parameter int CNT_W      = 8,
  parameter int CYC_W      = 16
) (
  input logic               clk_i,
  input logic               rst_i,
  phase_sequencer_if.slave  bus
);
  localparam int IDX_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      lenm1_q, lenm1_d;
  logic [NUM_PHASES-1:0] en_q, en_d;
  logic                  first_q, first_d;
  logic                  last_q, last_d;
  logic                  done_q, done_d;
  logic [CYC_W-1:0]      ccount_q, ccount_d;
  logic                  busy_q, busy_d;
  logic                  run_nxt, live_nxt;

  // Terminal count of phase k; a programmed length of 0 behaves as 1.
  function automatic logic [CNT_W-1:0] len_m1(input logic [NUM_PHASES*CNT_W-1:0] lens,
                                               input logic [IDX_W-1:0] k);
    logic [CNT_W-1:0] f;
    f = lens[int'(k)*CNT_W +: CNT_W];
    return (f == '0) ? '0 : f - CNT_W'(1);
  endfunction

  // The registers describe the clock now in progress; en_q says whether it consumed a count.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    lenm1_d = lenm1_q;
    case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          state_d = S_RUN;
          idx_d   = '0;
          cnt_d   = '0;
          lenm1_d = len_m1(bus.phase_len, '0);
        end
      end
      S_PAUSE: begin
        if (!bus.run) begin
          state_d = S_IDLE;
        end else if (bus.step) begin
          state_d = S_RUN;
          idx_d   = '0;
          cnt_d   = '0;
          lenm1_d = len_m1(bus.phase_len, '0);
        end
      end
      S_RUN: begin
        if (|en_q) begin
          if (cnt_q != lenm1_q) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else if (idx_q != LAST_IDX) begin
            cnt_d   = '0;
            idx_d   = idx_q + IDX_W'(1);
            lenm1_d = len_m1(bus.phase_len, idx_q + IDX_W'(1));
          end else begin
            cnt_d   = '0;
            idx_d   = '0;
            lenm1_d = len_m1(bus.phase_len, '0);
            if (!bus.run)          state_d = S_IDLE;
            else if (bus.step_mode) state_d = S_PAUSE;
            else                   state_d = S_RUN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    run_nxt  = (state_d == S_RUN);
    live_nxt = run_nxt && !bus.stall;
    en_d     = live_nxt ? (NUM_PHASES'(1) << idx_d) : '0;
    first_d  = run_nxt && (cnt_d == '0);
    last_d   = run_nxt && (cnt_d == lenm1_d);
    done_d   = live_nxt && last_d && (idx_d == LAST_IDX);
    ccount_d = done_d ? ccount_q + CYC_W'(1) : ccount_q;
    busy_d   = run_nxt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      en_q     <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      ccount_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      first_q  <= first_d;
      last_q   <= last_d;
      done_q   <= done_d;
      ccount_q <= ccount_d;
      busy_q   <= busy_d;
    end
  end

  // Latched phase length is only consulted while running, so it needs no reset.
  always_ff @(posedge clk_i) begin
    lenm1_q <= lenm1_d;
  end

  assign bus.phase_en    = en_q;
  assign bus.phase_idx   = idx_q;
  assign bus.phase_first = first_q;
  assign bus.phase_last  = last_q;
  assign bus.cycle_done  = done_q;
  assign bus.cycle_count = ccount_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_phase_sequencer.sv
// Directed scoreboard bench for phase_sequencer: 2-phase (CYC_W=4) and 3-phase instances.
module tb_phase_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  phase_sequencer_if #(.NUM_PHASES(2), .CNT_W(8), .CYC_W(4))  ifa ();
  phase_sequencer_if #(.NUM_PHASES(3), .CNT_W(8), .CYC_W(16)) ifb ();

  phase_sequencer #(.NUM_PHASES(2), .CNT_W(8), .CYC_W(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(ifa)
  );
  phase_sequencer #(.NUM_PHASES(3), .CNT_W(8), .CYC_W(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(ifb)
  );

  typedef struct packed {
    logic [2:0]  en;
    logic [1:0]  idx;
    logic        first;
    logic        last;
    logic        done;
    logic [15:0] cc;
    logic        busy;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  bit    sel_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  function automatic obs_t obs_a();
    obs_t o;
    o.en = 3'(ifa.phase_en);  o.idx = 2'(ifa.phase_idx);
    o.first = ifa.phase_first; o.last = ifa.phase_last; o.done = ifa.cycle_done;
    o.cc = 16'(ifa.cycle_count); o.busy = ifa.busy;
    return o;
  endfunction

  function automatic obs_t obs_b();
    obs_t o;
    o.en = 3'(ifb.phase_en);  o.idx = 2'(ifb.phase_idx);
    o.first = ifb.phase_first; o.last = ifb.phase_last; o.done = ifb.cycle_done;
    o.cc = 16'(ifb.cycle_count); o.busy = ifb.busy;
    return o;
  endfunction

  task automatic compare(input string tag, input obs_t o, input obs_t e);
    n_vec++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed en=%b idx=%0d first=%b last=%b done=%b cc=%0d busy=%b expected en=%b idx=%0d first=%b last=%b done=%b cc=%0d busy=%b",
             tag, o.en, o.idx, o.first, o.last, o.done, o.cc, o.busy,
             e.en, e.idx, e.first, e.last, e.done, e.cc, e.busy);
    end
  endtask

  task automatic push(input bit sel, input string tag, input logic [2:0] en, input logic [1:0] idx,
                      input logic f, input logic l, input logic d, input int cc, input logic b);
    obs_t e;
    e.en = en; e.idx = idx; e.first = f; e.last = l; e.done = d; e.cc = 16'(cc); e.busy = b;
    exp_q.push_back(e); tag_q.push_back(tag); sel_q.push_back(sel);
  endtask

  // Expected clock t (1-based from cycle start) for the 4,4 two-phase setup, cycle_count = base + completed.
  task automatic push_a44(input string tag, input int t, input int base);
    int p;
    p = (t - 1) % 8;
    push(1'b0, tag, (p < 4) ? 3'b001 : 3'b010, (p < 4) ? 2'd0 : 2'd1,
         (p % 4) == 0, (p % 4) == 3, p == 7, (base + t / 8) % 16, 1'b1);
  endtask

  task automatic push_idle(input bit sel, input string tag, input int cc);
    push(sel, tag, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, cc, 1'b0);
  endtask

  task automatic tick();
    obs_t  e;
    string tg;
    bit    s;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++; n_bad++;
      $error("FAIL scoreboard: observed empty queue, expected a pending entry");
    end else begin
      e = exp_q.pop_front(); tg = tag_q.pop_front(); s = sel_q.pop_front();
      compare(tg, s ? obs_b() : obs_a(), e);
    end
  endtask

  initial begin
    obs_t zero;
    zero = '0;
    ifa.run = 1'b0; ifa.step_mode = 1'b0; ifa.step = 1'b0; ifa.stall = 1'b0;
    ifa.phase_len = {8'd4, 8'd4};
    ifb.run = 1'b0; ifb.step_mode = 1'b0; ifb.step = 1'b0; ifb.stall = 1'b0;
    ifb.phase_len = {8'd2, 8'd0, 8'd3};

    @(posedge clk); @(posedge clk); #1;
    compare("reset_a", obs_a(), zero);
    compare("reset_b", obs_b(), zero);
    rst = 1'b0;
    push_idle(1'b0, "idle_wait", 0); tick();

    // Free run: 17 cycles, cycle_count wraps at 16; run dropped early in the last cycle.
    ifa.run = 1'b1;
    for (int t = 1; t <= 136; t++) begin
      push_a44("run44", t, 0);
      tick();
      if (t == 129) ifa.run = 1'b0;
    end
    push_idle(1'b0, "run_drop_idle", 1); tick();
    push_idle(1'b0, "run_drop_idle2", 1); tick();

    // Stall for 3 clocks starting on the 2nd clock of phase 1; length change mid-phase ignored.
    ifa.run = 1'b1;
    for (int s = 1; s <= 5; s++) begin
      push_a44("stall_pre", s, 1); tick();
      if (s == 1) ifa.run = 1'b0;
    end
    ifa.stall = 1'b1;
    ifa.phase_len = {8'd2, 8'd2};
    for (int s = 6; s <= 8; s++) begin
      push(1'b0, "stall_hold", 3'b000, 2'd1, 1'b0, 1'b0, 1'b0, 1, 1'b1); tick();
    end
    ifa.stall = 1'b0;
    push(1'b0, "stall_c1", 3'b010, 2'd1, 1'b0, 1'b0, 1'b0, 1, 1'b1); tick();
    push(1'b0, "stall_c2", 3'b010, 2'd1, 1'b0, 1'b0, 1'b0, 1, 1'b1); tick();
    push(1'b0, "stall_done", 3'b010, 2'd1, 1'b0, 1'b1, 1'b1, 2, 1'b1); tick();
    ifa.phase_len = {8'd4, 8'd4};
    push_idle(1'b0, "stall_idle", 2); tick();

    // Single-step mode; a step pulse while running is ignored.
    ifa.step_mode = 1'b1; ifa.run = 1'b1;
    for (int s = 1; s <= 8; s++) begin
      ifa.step = (s == 3);
      push_a44("step_c1", s, 2); tick();
    end
    ifa.step = 1'b0;
    push_idle(1'b0, "pause1", 3); tick();
    push_idle(1'b0, "pause2", 3); tick();
    ifa.step = 1'b1;
    for (int s = 1; s <= 8; s++) begin
      push_a44("step_c2", s, 3); tick();
      ifa.step = 1'b0;
    end
    push_idle(1'b0, "pause3", 4); tick();
    push_idle(1'b0, "pause4", 4); tick();
    ifa.step = 1'b1; ifa.run = 1'b0;
    push_idle(1'b0, "step_norun", 4); tick();
    ifa.step = 1'b0;
    push_idle(1'b0, "step_norun2", 4); tick();
    ifa.step_mode = 1'b0;

    // Asynchronous reset in the middle of phase 1.
    ifa.run = 1'b1;
    for (int s = 1; s <= 6; s++) begin
      push_a44("pre_rst", s, 4); tick();
    end
    #2 rst = 1'b1;
    #1 compare("rst_async", obs_a(), zero);
    ifa.run = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    push_idle(1'b0, "post_rst_idle", 0); tick();
    ifa.run = 1'b1;
    for (int s = 1; s <= 8; s++) begin
      push_a44("post_rst_run", s, 0); tick();
      ifa.run = 1'b0;
    end
    push_idle(1'b0, "post_rst_end", 1); tick();

    // Three phases with lengths 3, 0 (acts as 1), 2.
    ifb.run = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      int p;
      p = (t - 1) % 6;
      push(1'b1, "len302", (p < 3) ? 3'b001 : ((p == 3) ? 3'b010 : 3'b100),
           (p < 3) ? 2'd0 : ((p == 3) ? 2'd1 : 2'd2),
           (p == 0) || (p == 3) || (p == 4), (p == 2) || (p == 3) || (p == 5),
           p == 5, t / 6, 1'b1);
      tick();
      if (t == 12) ifb.run = 1'b0;
    end
    push_idle(1'b1, "len302_idle", 2); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion, expected summary before 200000");
    $fatal(1, "timeout");
  end
endmodule
